// File: rtl/pipelined_rca_if.sv
// Handshake and data bundle for pipelined_rca: operand set in, result out.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface pipelined_rca_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_rca.sv
// Ripple-carry adder/subtractor split into STAGES chunks of WIDTH/STAGES bits,
// one chunk per pipeline stage, with a valid/ready handshake and global stall.
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_rca_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a positive multiple of STAGES");
  end

  logic adv;

  // Stage k adds bit slice [k*CHUNK +: CHUNK]. Only the operand bits above
  // that slice move on, and the partial sum grows by one chunk per stage.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [CHUNK:0]      cc;
    logic [CHUNK-1:0]    s_chunk;
    logic [LO+CHUNK-1:0] s_d;
    logic [LO+CHUNK-1:0] s_q;
    logic                v_q;
    logic                c_q;

    if (k == 0) begin : g_src
      assign a_in = bus.in1;
      assign b_in = bus.in2 ^ {WIDTH{bus.sub}};
      assign c_in = bus.cin ^ bus.sub;
      assign v_in = bus.in_valid;
      assign s_d  = s_chunk;
    end else begin : g_src
      assign a_in = stg[k-1].g_ops.a_q;
      assign b_in = stg[k-1].g_ops.b_q;
      assign c_in = stg[k-1].c_q;
      assign v_in = stg[k-1].v_q;
      assign s_d  = {s_chunk, stg[k-1].s_q};
    end

    assign cc[0] = c_in;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      assign s_chunk[i] = a_in[i] ^ b_in[i] ^ cc[i];
      assign cc[i+1]    = (a_in[i] & b_in[i]) | (cc[i] & (a_in[i] ^ b_in[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= cc[CHUNK];
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:CHUNK];
          b_q <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cc[CHUNK] ^ cc[CHUNK-1];
        end
      end
    end
  end

  // Whole pipeline moves together; bubbles are kept, not squeezed out.
  assign adv           = ~stg[STAGES-1].v_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = stg[STAGES-1].v_q;
  assign bus.sum       = stg[STAGES-1].s_q;
  assign bus.cout      = stg[STAGES-1].c_q;
  assign bus.ovf       = stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: directed table, streaming/stall/reset
// sequences, and randomised handshake runs on three WIDTH/STAGES configurations.
module tb_pipelined_rca;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_rca_if #(.WIDTH(32)) bus32 ();
  pipelined_rca_if #(.WIDTH(8))  bus8  ();
  pipelined_rca_if #(.WIDTH(16)) bus16 ();

  pipelined_rca #(.WIDTH(32), .STAGES(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipelined_rca #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_rca #(.WIDTH(16), .STAGES(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for a w-bit add/subtract.
  function automatic logic [33:0] model(input int w, input logic [31:0] a_raw,
                                        input logic [31:0] b_raw, input logic ci, input logic su);
    logic [31:0] mask, msb, a, bb, s;
    logic [63:0] t;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    msb  = 32'h1 << (w - 1);
    a    = a_raw & mask;
    bb   = (su ? ~b_raw : b_raw) & mask;
    t    = {32'h0, a} + {32'h0, bb} + {63'h0, ci ^ su};
    s    = t[31:0] & mask;
    co   = (t >> w) != 64'h0;
    ov   = (((a & msb) != 0) == ((bb & msb) != 0)) && (((s & msb) != 0) != ((a & msb) != 0));
    return {ov, co, s};
  endfunction

  task automatic drive(input int sel, input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic su, input logic ordy);
    case (sel)
      0: begin
        bus8.in_valid = iv; bus8.in1 = a[7:0]; bus8.in2 = b[7:0];
        bus8.cin = ci; bus8.sub = su; bus8.out_ready = ordy;
      end
      1: begin
        bus16.in_valid = iv; bus16.in1 = a[15:0]; bus16.in2 = b[15:0];
        bus16.cin = ci; bus16.sub = su; bus16.out_ready = ordy;
      end
      default: begin
        bus32.in_valid = iv; bus32.in1 = a; bus32.in2 = b;
        bus32.cin = ci; bus32.sub = su; bus32.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic irdy, output logic ov, output logic [31:0] s,
                        output logic co, output logic of);
    case (sel)
      0: begin
        irdy = bus8.in_ready; ov = bus8.out_valid; s = {24'h0, bus8.sum};
        co = bus8.cout; of = bus8.ovf;
      end
      1: begin
        irdy = bus16.in_ready; ov = bus16.out_valid; s = {16'h0, bus16.sum};
        co = bus16.cout; of = bus16.ovf;
      end
      default: begin
        irdy = bus32.in_ready; ov = bus32.out_valid; s = bus32.sum;
        co = bus32.cout; of = bus32.ovf;
      end
    endcase
  endtask

  // Ten sets i, i*0x01010101 back to back; mode 1 drops out_ready in cycles 6..9.
  task automatic run_stream(input int mode);
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [31:0] held;
    int sent, recv;
    sent = 0; recv = 0; held = '0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clk);
      drive(2, sent < 10, 32'(sent), 32'(sent) * 32'h0101_0101, 1'b0, 1'b0,
            !(mode == 1 && c >= 6 && c <= 9));
      #1;
      if (mode == 0) check("stream_oval", 32'(bus32.out_valid), 32'(c >= 4 && c < 14));
      if (mode == 1 && c <= 12) check("stall_irdy", 32'(bus32.in_ready), 32'(!(c >= 6 && c <= 9)));
      if (mode == 1 && c == 6) held = bus32.sum;
      if (mode == 1 && c >= 7 && c <= 9) begin
        check("stall_frozen_sum", bus32.sum, held);
        check("stall_frozen_oval", 32'(bus32.out_valid), 32'd1);
      end
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_sum", bus32.sum, e[31:0]);
          check("stream_cout", 32'(bus32.cout), 32'(e[32]));
          check("stream_ovf", 32'(bus32.ovf), 32'(e[33]));
        end
        recv++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(model(32, bus32.in1, bus32.in2, 1'b0, 1'b0));
        sent++;
      end
    end
    check("stream_count", 32'(recv), 32'd10);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      #1;
      check("stream_drained", 32'(bus32.out_valid), 32'd0);
    end
  endtask

  // Random operands with random in_valid; out_ready forced high for the first
  // 60 cycles so latency must be exactly stg there.
  task automatic rnd_stream(input int sel, input int n);
    logic [33:0] exp_q[$];
    int          acc_q[$];
    logic [33:0] e;
    logic [31:0] a, b, s;
    logic        ci, su, pend, iv, ordy, irdy, ov, co, of;
    int          w, stg, sent, recv, bound, ca;
    w   = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
    stg = (sel == 0) ? 2 : (sel == 1) ? 1 : 4;
    sent = 0; recv = 0; pend = 1'b0; bound = n * 4 + 200;
    a = '0; b = '0; ci = 1'b0; su = 1'b0;
    for (int c = 0; c < bound && recv < n; c++) begin
      @(negedge clk);
      if (!pend && sent < n) begin
        a = $urandom; b = $urandom;
        ci = 1'($urandom_range(0, 1)); su = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      iv   = pend && ($urandom_range(0, 3) != 0);
      ordy = (c < 60) ? 1'b1 : ($urandom_range(0, 2) != 0);
      drive(sel, iv, a, b, ci, su, ordy);
      #1;
      sample(sel, irdy, ov, s, co, of);
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_out", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ca = acc_q.pop_front();
          check("rnd_sum", s, e[31:0]);
          check("rnd_cout", 32'(co), 32'(e[32]));
          check("rnd_ovf", 32'(of), 32'(e[33]));
          if (c < 60) check("rnd_latency", 32'(c - ca), 32'(stg));
        end
        recv++;
      end
      if (iv && irdy) begin
        exp_q.push_back(model(w, a, b, ci, su));
        acc_q.push_back(c);
        sent++;
        pend = 1'b0;
      end
    end
    check("rnd_count", 32'(recv), 32'(n));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(sel, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      #1;
      sample(sel, irdy, ov, s, co, of);
      check("rnd_drained", 32'(ov), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   lat;
    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    tbl[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    tbl[6]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    tbl[10] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    tbl[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #2;
    check("rst_oval", 32'(bus32.out_valid), 32'd0);
    check("rst_sum", bus32.sum, 32'd0);
    check("rst_cout", 32'(bus32.cout), 32'd0);
    check("rst_ovf", 32'(bus32.ovf), 32'd0);
    check("rst_irdy", 32'(bus32.in_ready), 32'd1);
    check("rst_oval8", 32'(bus8.out_valid), 32'd0);
    check("rst_oval16", 32'(bus16.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_irdy", 32'(bus32.in_ready), 32'd1);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(2, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1);
      #1;
      check("vec_irdy", 32'(bus32.in_ready), 32'd1);
      @(negedge clk);
      bus32.in_valid = 1'b0;
      lat = 1;
      while (!bus32.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("vec_latency", 32'(lat), 32'd4);
      check("vec_sum", bus32.sum, tbl[i].sum);
      check("vec_cout", 32'(bus32.cout), 32'(tbl[i].cout));
      check("vec_ovf", 32'(bus32.ovf), 32'(tbl[i].ovf));
    end
    @(negedge clk);

    run_stream(0);
    run_stream(1);

    // Three sets in flight, result 0 held at the output, then a one-cycle reset.
    @(negedge clk);
    drive(2, 1'b1, 32'hC000_0000, 32'h9000_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 32'h0000_0009, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_oval", 32'(bus32.out_valid), 32'd1);
    check("pre_rst_sum", bus32.sum, 32'h5000_0001);
    check("pre_rst_cout", 32'(bus32.cout), 32'd1);
    check("pre_rst_ovf", 32'(bus32.ovf), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_oval", 32'(bus32.out_valid), 32'd0);
    check("midrst_sum", bus32.sum, 32'd0);
    check("midrst_cout", 32'(bus32.cout), 32'd0);
    check("midrst_ovf", 32'(bus32.ovf), 32'd0);
    check("midrst_irdy", 32'(bus32.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    #1;
    check("rel_irdy", 32'(bus32.in_ready), 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      check("rel_no_ghost", 32'(bus32.out_valid), 32'd0);
    end

    rnd_stream(2, 10000);
    rnd_stream(0, 2000);
    rnd_stream(1, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, CHUNK = WIDTH/STAGES.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: operand set on in1/in2/cin/sub is valid.
REQ-006 Port in_ready, output, 1: block accepts an operand set this cycle.
REQ-007 Port in1, input, WIDTH: first operand.
REQ-008 Port in2, input, WIDTH: second operand.
REQ-009 Port cin, input, 1: carry-in at bit 0.
REQ-010 Port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 Port out_valid, output, 1: sum/cout/ovf hold a valid result.
REQ-012 Port out_ready, input, 1: downstream accepts the result this cycle.
REQ-013 Port sum, output, WIDTH: result.
REQ-014 Port cout, output, 1: carry out of bit WIDTH-1.
REQ-015 Port ovf, output, 1: signed two's-complement overflow.

Function
REQ-016 Effective operand b' SHALL be in2 XOR {WIDTH{sub}}; effective carry-in SHALL be cin XOR sub (sub=1, cin=0 gives in1-in2; cout=1 means no borrow).
REQ-017 Stage k (0..STAGES-1) SHALL ripple-add bits [k*CHUNK +: CHUNK] of in1 and b' using the carry registered by stage k-1 (stage 0 uses effective carry-in).
REQ-018 Operand bits not yet consumed SHALL travel in pipeline registers alongside completed sum chunks; each stage register SHALL hold a valid bit.
REQ-019 Advance enable adv SHALL equal (NOT out_valid) OR out_ready; all stage registers SHALL load only when adv=1, otherwise hold.
REQ-020 in_ready SHALL equal adv, combinationally; a transfer occurs when in_valid AND in_ready.
REQ-021 When adv=1 and no input transfer, stage 0 SHALL load valid=0 (bubble); bubbles are not collapsed.
REQ-022 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with out_ready held high.
REQ-023 Throughput SHALL be one result per cycle while in_valid and out_ready stay high.
REQ-024 out_valid SHALL be the last stage's valid bit; sum/cout/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 Results SHALL exit in acceptance order; no operand set SHALL be dropped or duplicated under any out_ready pattern.
REQ-027 STAGES=1 SHALL yield a single registered WIDTH-bit ripple adder with latency 1.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; sum wraps, cout reports the carry.

Reset
REQ-029 rst_n low SHALL asynchronously clear all valid bits, out_valid, sum, cout and ovf to 0.
REQ-030 Operations in flight at reset assertion SHALL be discarded; none SHALL emerge after release.
REQ-031 in_ready SHALL be 1 while rst_n is low and on the first cycle after release (pipeline empty).

Verification (WIDTH=32, STAGES=4)
REQ-032 in1=0xFFFFFFFF, in2=1, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000000, cout=1, ovf=0.
REQ-033 in1=5, in2=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; in1=0x7FFFFFFF, in2=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 Stream 10 sets i+i*0x01010101 (i=0..9) back-to-back, out_ready=1 -> 10 consecutive out_valid cycles, correct sums in order, starting cycle 4.
REQ-035 Same stream with out_ready low for cycles 6-9 -> in_ready=0 in those cycles, outputs frozen, no loss or duplication, order preserved.
REQ-036 Accept 3 sets, assert rst_n=0 mid-flight for 1 cycle -> all outputs 0 immediately, no out_valid for the discarded sets afterward.
REQ-037 Random add/sub with random in_valid/out_ready, 10k sets, also WIDTH=8 STAGES=2 and WIDTH=16 STAGES=1 -> all results match reference model.
